// File: rtl/multicycle_control_unit_pkg.sv
// rtl/multicycle_control_unit_pkg.sv - shared types and constants for the multi-cycle control unit
//
// Purpose: opcode / instruction-class encodings, FSM state and PC-source
// enums, branch funct3 constants and the opcode-vs-class legality check.
package multicycle_control_unit_pkg;

    typedef enum logic [6:0] {
        LOAD     = 7'b0000011,
        LOAD_FP  = 7'b0000111,
        MISC_MEM = 7'b0001111,
        OP_IMM   = 7'b0010011,
        AUIPC    = 7'b0010111,
        STORE    = 7'b0100011,
        STORE_FP = 7'b0100111,
        OP       = 7'b0110011,
        LUI      = 7'b0110111,
        BRANCH   = 7'b1100011,
        JALR     = 7'b1100111,
        JAL      = 7'b1101111,
        SYSTEM   = 7'b1110011
    } instruction_format_type;

    typedef enum logic [2:0] {
        R_TYPE = 3'd0,
        I_TYPE = 3'd1,
        S_TYPE = 3'd2,
        B_TYPE = 3'd3,
        U_TYPE = 3'd4,
        J_TYPE = 3'd5
    } instruction_op_type;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EXEC = 3'd1,
        MEM  = 3'd2,
        WB   = 3'd3,
        ERR  = 3'd4
    } ctrl_state_t;

    typedef enum logic [1:0] {
        PC_SEQ = 2'b00,
        PC_IMM = 2'b01,
        PC_REG = 2'b10
    } pc_src_t;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // op is the opcode with its low bits normalised to 2'b11, so compressed
    // encodings are checked against the same class table.
    function automatic logic class_matches(instruction_op_type ot, instruction_format_type op);
        case (ot)
            R_TYPE:  return op == OP;
            I_TYPE:  return op inside {LOAD, LOAD_FP, OP_IMM, JALR, SYSTEM, MISC_MEM};
            S_TYPE:  return op inside {STORE, STORE_FP};
            B_TYPE:  return op == BRANCH;
            U_TYPE:  return op inside {LUI, AUIPC};
            J_TYPE:  return op == JAL;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_unit_branch_compare.sv
// rtl/multicycle_control_unit_branch_compare.sv - combinational branch condition evaluator
//
// Purpose: decides whether a conditional branch is taken.
// Ports:
//   funct3_i  branch funct3
//   rs1_i     source operand 1
//   rs2_i     source operand 2
//   taken_o   1 = branch condition holds (funct3 010/011 never taken)
module multicycle_control_unit_branch_compare
    import multicycle_control_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            taken_o
);

    always_comb begin
        taken_o = 1'b0;
        case (funct3_i)
            F3_BEQ:  taken_o = (rs1_i == rs2_i);
            F3_BNE:  taken_o = (rs1_i != rs2_i);
            F3_BLT:  taken_o = ($signed(rs1_i) <  $signed(rs2_i));
            F3_BGE:  taken_o = ($signed(rs1_i) >= $signed(rs2_i));
            F3_BLTU: taken_o = (rs1_i <  rs2_i);
            F3_BGEU: taken_o = (rs1_i >= rs2_i);
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multi-cycle RV32 control sequencer with memory handshake
//
// Purpose: steps each instruction through ACCEPT(IDLE), EXEC, MEM and WB,
// issuing registered control strobes and a req/ack data-memory handshake
// with a bounded wait.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   instr_valid / instr_ready  instruction handshake from the decoder
//   opcode, optype, funct3     decoded instruction fields
//   rs1_data, rs2_data         register operands, sampled in EXEC
//   mem_req/mem_we/mem_size    data-memory request, held until mem_ack
//   mem_ack                    memory completion
//   ctrl_*                     datapath / PC control
//   illegal_instr              sticky illegal-class flag
//   mem_timeout_err            sticky memory timeout flag
module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int MEM_WAIT_MAX = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   instr_valid,
    output logic                   instr_ready,
    input  instruction_format_type opcode,
    input  instruction_op_type     optype,
    input  logic [2:0]             funct3,
    input  logic [XLEN-1:0]        rs1_data,
    input  logic [XLEN-1:0]        rs2_data,
    input  logic                   mem_ack,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [2:0]             mem_size,
    output logic                   ctrl_alu_src,
    output logic                   ctrl_mem2reg,
    output logic                   ctrl_reg_write,
    output logic                   ctrl_AUIPC_taken,
    output logic [1:0]             ctrl_pc_src,
    output logic                   ctrl_pc_update,
    output logic                   ctrl_prev_is_compressed,
    output logic                   illegal_instr,
    output logic                   mem_timeout_err
);

    localparam int CNT_W = $clog2(MEM_WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_WAIT_MAX - 1);

    ctrl_state_t            state_q;
    instruction_format_type opcode_q;
    instruction_op_type     optype_q;
    logic [2:0]             funct3_q;
    logic                   compressed_q;
    logic [CNT_W-1:0]       wait_cnt_q;

    logic       instr_ready_q;
    logic       mem_req_q;
    logic       mem_we_q;
    logic [2:0] mem_size_q;
    logic       alu_src_q;
    logic       mem2reg_q;
    logic       reg_write_q;
    logic       auipc_q;
    pc_src_t    pc_src_q;
    logic       pc_update_q;
    logic       illegal_q;
    logic       timeout_q;

    // Compressed encodings share the class table of their 32-bit forms.
    instruction_format_type opcode_base;
    assign opcode_base = instruction_format_type'({opcode[6:2], 2'b11});

    logic    branch_taken;
    logic    is_load_d;
    logic    is_store_d;
    logic    alu_src_d;
    pc_src_t pc_src_d;

    multicycle_control_unit_branch_compare #(
        .XLEN (XLEN)
    ) u_branch_compare (
        .funct3_i (funct3_q),
        .rs1_i    (rs1_data),
        .rs2_i    (rs2_data),
        .taken_o  (branch_taken)
    );

    always_comb begin
        is_load_d  = opcode_q inside {LOAD, LOAD_FP};
        is_store_d = opcode_q inside {STORE, STORE_FP};
        alu_src_d  = optype_q inside {I_TYPE, S_TYPE, U_TYPE};
        pc_src_d   = PC_SEQ;
        if (optype_q == B_TYPE) begin
            pc_src_d = branch_taken ? PC_IMM : PC_SEQ;
        end else if (opcode_q == JAL) begin
            pc_src_d = PC_IMM;
        end else if (opcode_q == JALR) begin
            pc_src_d = PC_REG;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            opcode_q      <= instruction_format_type'(7'd0);
            optype_q      <= instruction_op_type'(3'd0);
            funct3_q      <= 3'd0;
            compressed_q  <= 1'b0;
            wait_cnt_q    <= '0;
            instr_ready_q <= 1'b1;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_size_q    <= 3'd0;
            alu_src_q     <= 1'b0;
            mem2reg_q     <= 1'b0;
            reg_write_q   <= 1'b0;
            auipc_q       <= 1'b0;
            pc_src_q      <= PC_SEQ;
            pc_update_q   <= 1'b0;
            illegal_q     <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            reg_write_q <= 1'b0;
            pc_update_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (instr_valid) begin
                        opcode_q      <= opcode_base;
                        optype_q      <= optype;
                        funct3_q      <= funct3;
                        compressed_q  <= (opcode[1:0] != 2'b11);
                        instr_ready_q <= 1'b0;
                        if (class_matches(optype, opcode_base)) begin
                            state_q <= EXEC;
                        end else begin
                            state_q   <= ERR;
                            illegal_q <= 1'b1;
                        end
                    end
                end

                EXEC: begin
                    alu_src_q  <= alu_src_d;
                    auipc_q    <= (opcode_q == AUIPC);
                    mem2reg_q  <= is_load_d;
                    pc_src_q   <= pc_src_d;
                    mem_we_q   <= is_store_d;
                    mem_size_q <= (is_load_d || is_store_d) ? funct3_q : 3'd0;
                    if (is_load_d || is_store_d) begin
                        state_q    <= MEM;
                        mem_req_q  <= 1'b1;
                        wait_cnt_q <= '0;
                    end else if (optype_q == B_TYPE) begin
                        state_q       <= IDLE;
                        pc_update_q   <= 1'b1;
                        instr_ready_q <= 1'b1;
                    end else begin
                        state_q     <= WB;
                        reg_write_q <= 1'b1;
                        pc_update_q <= 1'b1;
                    end
                end

                MEM: begin
                    // An ack in the final allowed cycle still completes normally.
                    if (mem_ack) begin
                        mem_req_q  <= 1'b0;
                        wait_cnt_q <= '0;
                        if (mem_we_q) begin
                            state_q       <= IDLE;
                            pc_update_q   <= 1'b1;
                            instr_ready_q <= 1'b1;
                        end else begin
                            state_q     <= WB;
                            reg_write_q <= 1'b1;
                            pc_update_q <= 1'b1;
                        end
                    end else if (wait_cnt_q == CNT_LAST) begin
                        state_q    <= ERR;
                        mem_req_q  <= 1'b0;
                        timeout_q  <= 1'b1;
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    end
                end

                WB: begin
                    state_q       <= IDLE;
                    instr_ready_q <= 1'b1;
                end

                ERR: begin
                    instr_ready_q <= 1'b0;
                    mem_req_q     <= 1'b0;
                end

                default: begin
                    state_q       <= ERR;
                    instr_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign instr_ready             = instr_ready_q;
    assign mem_req                 = mem_req_q;
    assign mem_we                  = mem_we_q;
    assign mem_size                = mem_size_q;
    assign ctrl_alu_src            = alu_src_q;
    assign ctrl_mem2reg            = mem2reg_q;
    assign ctrl_reg_write          = reg_write_q;
    assign ctrl_AUIPC_taken        = auipc_q;
    assign ctrl_pc_src             = pc_src_q;
    assign ctrl_pc_update          = pc_update_q;
    assign ctrl_prev_is_compressed = compressed_q;
    assign illegal_instr           = illegal_q;
    assign mem_timeout_err         = timeout_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - randomized self-checking bench for multicycle_control_unit
module tb_multicycle_control_unit;
    import multicycle_control_unit_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, rst_n_t;
    logic instr_valid, instr_valid_t, mem_ack, mem_ack_t;
    instruction_format_type opcode;
    instruction_op_type     optype;
    logic [2:0]  funct3;
    logic [31:0] rs1_data, rs2_data;

    logic instr_ready, mem_req, mem_we, ctrl_alu_src, ctrl_mem2reg, ctrl_reg_write;
    logic ctrl_AUIPC_taken, ctrl_pc_update, ctrl_prev_is_compressed, illegal_instr, mem_timeout_err;
    logic [2:0] mem_size;
    logic [1:0] ctrl_pc_src;

    logic t_instr_ready, t_mem_req, t_mem_we, t_alu_src, t_mem2reg, t_reg_write;
    logic t_auipc, t_pc_update, t_compressed, t_illegal, t_timeout;
    logic [2:0] t_mem_size;
    logic [1:0] t_pc_src;

    multicycle_control_unit #(.XLEN(32), .MEM_WAIT_MAX(255)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .opcode(opcode), .optype(optype), .funct3(funct3),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
        .ctrl_alu_src(ctrl_alu_src), .ctrl_mem2reg(ctrl_mem2reg), .ctrl_reg_write(ctrl_reg_write),
        .ctrl_AUIPC_taken(ctrl_AUIPC_taken), .ctrl_pc_src(ctrl_pc_src), .ctrl_pc_update(ctrl_pc_update),
        .ctrl_prev_is_compressed(ctrl_prev_is_compressed), .illegal_instr(illegal_instr),
        .mem_timeout_err(mem_timeout_err)
    );

    multicycle_control_unit #(.XLEN(32), .MEM_WAIT_MAX(4)) dut_t (
        .clk(clk), .rst_n(rst_n_t), .instr_valid(instr_valid_t), .instr_ready(t_instr_ready),
        .opcode(opcode), .optype(optype), .funct3(funct3),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .mem_ack(mem_ack_t),
        .mem_req(t_mem_req), .mem_we(t_mem_we), .mem_size(t_mem_size),
        .ctrl_alu_src(t_alu_src), .ctrl_mem2reg(t_mem2reg), .ctrl_reg_write(t_reg_write),
        .ctrl_AUIPC_taken(t_auipc), .ctrl_pc_src(t_pc_src), .ctrl_pc_update(t_pc_update),
        .ctrl_prev_is_compressed(t_compressed), .illegal_instr(t_illegal),
        .mem_timeout_err(t_timeout)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] outs();
        return {instr_ready, mem_req, mem_we, mem_size, ctrl_alu_src, ctrl_mem2reg, ctrl_reg_write,
                ctrl_AUIPC_taken, ctrl_pc_src, ctrl_pc_update, ctrl_prev_is_compressed,
                illegal_instr, mem_timeout_err};
    endfunction

    // Legal (class, opcode) pairs used by the random stream.
    logic [2:0] legal_ot [12] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd4, 3'd4};
    logic [6:0] legal_op [12] = '{7'b0110011, 7'b0000011, 7'b0000111, 7'b0010011, 7'b1100111, 7'b1110011,
                                 7'b0001111, 7'b0100011, 7'b0100111, 7'b1100011, 7'b0110111, 7'b0010111};

    task automatic garbage();
        opcode   = instruction_format_type'(7'($urandom));
        optype   = instruction_op_type'(3'($urandom));
        funct3   = 3'($urandom);
        rs1_data = $urandom;
        rs2_data = $urandom;
    endtask

    // Reference: expected per-cycle activity computed from the instruction's class rules.
    // Cycle 1 is the accept cycle; call at posedge+1.
    task automatic run_instr(input logic [2:0] ot, input logic [6:0] op, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] b, input int d, input string nm);
        logic [6:0]  base;
        logic        comp, ld, st, mem, br, wr, tk;
        logic [1:0]  exp_src;
        int          idle, pu_c;
        logic [31:0] rw_e, pu_e, mr_e, rdy_e, rw_o, pu_o, mr_o, rdy_o;
        logic [1:0]  src_o;
        logic        alu_o, m2r_o, aui_o, cmp_o, we_o;
        logic [2:0]  sz_o;
        base = {op[6:2], 2'b11};
        comp = (op[1:0] != 2'b11);
        ld   = (base == 7'b0000011) || (base == 7'b0000111);
        st   = (base == 7'b0100011) || (base == 7'b0100111);
        mem  = ld || st;
        br   = (ot == 3'd3);
        tk   = 1'b0;
        if (br) begin
            case (f3)
                3'd0: tk = (a == b);
                3'd1: tk = (a != b);
                3'd4: tk = ($signed(a) <  $signed(b));
                3'd5: tk = ($signed(a) >= $signed(b));
                3'd6: tk = (a <  b);
                3'd7: tk = (a >= b);
                default: tk = 1'b0;
            endcase
        end
        exp_src = br ? (tk ? 2'b01 : 2'b00) : (base == 7'b1101111) ? 2'b01 : (base == 7'b1100111) ? 2'b10 : 2'b00;
        wr    = !br && !st;
        idle  = br ? 3 : st ? 4 + d : ld ? 5 + d : 4;
        pu_c  = wr ? idle - 1 : idle;
        rw_e  = wr ? (32'd1 << (idle - 1)) : 32'd0;
        pu_e  = 32'd1 << pu_c;
        mr_e  = 32'd0;
        if (mem) for (int c = 3; c <= 3 + d; c++) mr_e[c] = 1'b1;
        rdy_e = (32'd1 << 1) | (32'd1 << idle);
        rw_o = 0; pu_o = 0; mr_o = 0; rdy_o = 0;
        src_o = 0; alu_o = 0; m2r_o = 0; aui_o = 0; cmp_o = 0; we_o = 0; sz_o = 0;
        for (int c = 1; c <= idle; c++) begin
            garbage();
            if (c == 1) begin
                instr_valid = 1'b1;
                opcode = instruction_format_type'(op);
                optype = instruction_op_type'(ot);
                funct3 = f3;
            end else begin
                instr_valid = (c < idle) ? 1'($urandom) : 1'b0;
                if (c == 2) begin
                    rs1_data = a;
                    rs2_data = b;
                end
            end
            mem_ack = (mem && c >= 3 && c <= 3 + d) ? (c == 3 + d) : 1'($urandom);
            @(negedge clk);
            rw_o[c]  = ctrl_reg_write;
            pu_o[c]  = ctrl_pc_update;
            mr_o[c]  = mem_req;
            rdy_o[c] = instr_ready;
            if (c == pu_c) begin
                src_o = ctrl_pc_src; alu_o = ctrl_alu_src; m2r_o = ctrl_mem2reg;
                aui_o = ctrl_AUIPC_taken; cmp_o = ctrl_prev_is_compressed;
            end
            if (mem && c == 3 + d) begin
                we_o = mem_we; sz_o = mem_size;
            end
            @(posedge clk); #1;
        end
        instr_valid = 1'b0;
        mem_ack     = 1'b0;
        check({nm, "/reg_write_cycles"}, rw_o, rw_e);
        check({nm, "/pc_update_cycles"}, pu_o, pu_e);
        check({nm, "/mem_req_cycles"}, mr_o, mr_e);
        check({nm, "/instr_ready_cycles"}, rdy_o, rdy_e);
        check({nm, "/pc_src"}, src_o, exp_src);
        check({nm, "/alu_src"}, alu_o, (ot == 3'd1) || (ot == 3'd2) || (ot == 3'd4));
        check({nm, "/mem2reg"}, m2r_o, ld);
        check({nm, "/auipc"}, aui_o, base == 7'b0010111);
        check({nm, "/compressed"}, cmp_o, comp);
        if (mem) begin
            check({nm, "/mem_we"}, we_o, st);
            check({nm, "/mem_size"}, sz_o, f3);
        end
        check({nm, "/sticky_flags"}, {illegal_instr, mem_timeout_err}, 2'b00);
    endtask

    task automatic run_illegal(input logic [2:0] ot, input logic [6:0] op, input string nm);
        garbage();
        instr_valid = 1'b1;
        opcode = instruction_format_type'(op);
        optype = instruction_op_type'(ot);
        @(posedge clk); #1;
        for (int c = 0; c < 4; c++) begin
            garbage();
            instr_valid = 1'($urandom);
            mem_ack     = 1'($urandom);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check({nm, "/illegal_instr"}, illegal_instr, 1'b1);
        check({nm, "/err_quiet"}, {instr_ready, ctrl_reg_write, ctrl_pc_update, mem_req}, 4'b0000);
        @(posedge clk); #1;
        instr_valid = 1'b0; mem_ack = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check({nm, "/after_reset"}, outs(), 16'h8000);
        @(posedge clk); #1;
    endtask

    // Store on the MEM_WAIT_MAX=4 instance; ack_cyc 0 means no ack.
    task automatic run_t(input int ack_cyc, input logic [31:0] mr_e, input logic [31:0] pu_e,
                         input logic [31:0] rdy_e, input logic err_e, input string nm);
        logic [31:0] mr_o, pu_o, rdy_o;
        logic        err_o;
        mr_o = 0; pu_o = 0; rdy_o = 0; err_o = 0;
        rst_n_t = 1'b0;
        @(posedge clk); #1;
        rst_n_t = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            garbage();
            if (c == 1) begin
                opcode = STORE; optype = S_TYPE; funct3 = 3'b010;
            end
            instr_valid_t = (c == 1) || (ack_cyc == 0 && c >= 7);
            mem_ack_t     = (ack_cyc == 0) ? (c >= 7 && 1'($urandom)) : (c == ack_cyc);
            @(negedge clk);
            mr_o[c]  = t_mem_req;
            pu_o[c]  = t_pc_update;
            rdy_o[c] = t_instr_ready;
            if (c == 8) err_o = t_timeout;
            @(posedge clk); #1;
        end
        instr_valid_t = 1'b0; mem_ack_t = 1'b0;
        check({nm, "/mem_req_cycles"}, mr_o, mr_e);
        check({nm, "/pc_update_cycles"}, pu_o, pu_e);
        check({nm, "/instr_ready_cycles"}, rdy_o, rdy_e);
        check({nm, "/mem_timeout_err"}, err_o, err_e);
    endtask

    initial begin
        rst_n = 1'b0; rst_n_t = 1'b0;
        instr_valid = 1'b0; instr_valid_t = 1'b0;
        mem_ack = 1'b0; mem_ack_t = 1'b0;
        garbage();
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_outputs", outs(), 16'h8000);
        @(posedge clk); #1;
        rst_n = 1'b1; rst_n_t = 1'b1;

        run_instr(3'd0, 7'b0110011, 3'b000, $urandom, $urandom, 0, "add");
        run_instr(3'd3, 7'b1100011, 3'b100, 32'hFFFF_FFFF, 32'd1, 0, "blt");
        run_instr(3'd3, 7'b1100011, 3'b110, 32'hFFFF_FFFF, 32'd1, 0, "bltu");
        run_instr(3'd3, 7'b1100011, 3'b011, 32'h1234, 32'h1234, 0, "br_f3_011");
        run_instr(3'd1, 7'b0000011, 3'b010, $urandom, $urandom, 5, "lw");
        run_instr(3'd2, 7'b0100011, 3'b010, $urandom, $urandom, 0, "sw");
        run_instr(3'd1, 7'b1100101, 3'b000, $urandom, $urandom, 0, "c_jalr");
        run_instr(3'd5, 7'b1101111, 3'b000, $urandom, $urandom, 0, "jal");
        run_instr(3'd4, 7'b0010111, 3'b000, $urandom, $urandom, 0, "auipc");

        for (int i = 0; i < 200; i++) begin
            int          k;
            logic [6:0]  op;
            logic [31:0] a, b;
            k  = $urandom_range(0, 11);
            op = legal_op[k];
            if ($urandom_range(0, 3) == 0) op[1:0] = 2'b01;
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = a ^ 32'h8000_0000;
                default: b = $urandom;
            endcase
            run_instr(legal_ot[k], op, 3'($urandom), a, b, $urandom_range(0, 7), "rand");
        end

        run_illegal(3'd7, 7'b0110011, "bad_optype");
        run_illegal(3'd2, 7'b0110011, "s_not_store");
        run_illegal(3'd3, 7'b1101111, "b_not_branch");

        // Reset in the middle of a load's MEM phase.
        garbage();
        instr_valid = 1'b1; mem_ack = 1'b0;
        opcode = instruction_format_type'(7'b0000001); optype = I_TYPE; funct3 = 3'b010;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("rst_mid/mem_req_before", mem_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid/async_outputs", outs(), 16'h8000);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_mid/ready_after", instr_ready, 1'b1);
        @(posedge clk); #1;
        run_instr(3'd0, 7'b0110011, 3'b000, $urandom, $urandom, 0, "add_after_rst");

        run_t(0, 32'h78, 32'h0,  32'h002, 1'b1, "sw_timeout");
        @(negedge clk);
        check("sw_timeout/ready_stays_low", t_instr_ready, 1'b0);
        @(posedge clk); #1;
        run_t(6, 32'h78, 32'h80, 32'h182, 1'b0, "sw_ack_at_limit");
        run_t(3, 32'h08, 32'h10, 32'h1F2, 1'b0, "sw_ack_first");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
